// File: rtl/dac_xy.sv
// rtl/dac_xy.sv - XY vector DAC output stage: point FIFO plus settle/hold dwell FSM.
// Define DAC_XY_BLANK_EN to blank the beam colours while the DAC settles.
module dac_xy #(
  parameter int DATA_WIDTH      = 10,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int SETTLE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int INVERT_X        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_x,
  input  logic [DATA_WIDTH-1:0] s_y,
  input  logic                  s_red,
  input  logic                  s_grn,
  input  logic                  s_blu,
  output logic [DATA_WIDTH-1:0] dac_x_io,
  output logic [DATA_WIDTH-1:0] dac_y_io,
  output logic                  dac_red_io,
  output logic                  dac_grn_io,
  output logic                  dac_blu_io,
  output logic                  busy
);

  localparam int DEPTH   = 1 << FIFO_ADDR_WIDTH;
  localparam int ENTRY_W = 2 * DATA_WIDTH + 3;
  localparam int MAX_CYC = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

`ifdef DAC_XY_BLANK_EN
  localparam bit BLANK_SETTLE = 1'b1;
`else
  localparam bit BLANK_SETTLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [ENTRY_W-1:0]         mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
  logic                       s_ready_q;
  logic                       push, pop, empty;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      x_q, x_d, y_q, y_d;
  logic [2:0]                 rgb_q, rgb_d, pt_rgb_q, pt_rgb_d;

  logic [ENTRY_W-1:0]         head;
  logic [DATA_WIDTH-1:0]      head_x, head_y, head_x_pin;
  logic [2:0]                 head_rgb;

  assign push  = s_valid && s_ready_q;
  assign empty = (count_q == '0);

  assign head       = mem_q[rd_ptr_q];
  assign head_x     = head[ENTRY_W-1 -: DATA_WIDTH];
  assign head_y     = head[3 +: DATA_WIDTH];
  assign head_rgb   = head[2:0];
  assign head_x_pin = (INVERT_X != 0) ? ~head_x : head_x;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_x, s_y, s_red, s_grn, s_blu};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Ready looks ahead at the post-edge count so it drops exactly when the FIFO fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      s_ready_q <= (count_d != FULL_COUNT);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    rgb_d    = rgb_q;
    pt_rgb_d = pt_rgb_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          x_d      = head_x_pin;
          y_d      = head_y;
          pt_rgb_d = head_rgb;
          rgb_d    = BLANK_SETTLE ? 3'b000 : head_rgb;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LOAD;
          rgb_d   = pt_rgb_q;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop      = 1'b1;
            x_d      = head_x_pin;
            y_d      = head_y;
            pt_rgb_d = head_rgb;
            rgb_d    = BLANK_SETTLE ? 3'b000 : head_rgb;
            cnt_d    = SETTLE_LOAD;
            state_d  = SETTLE;
          end else begin
            rgb_d   = 3'b000;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      pt_rgb_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
      pt_rgb_q <= pt_rgb_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign dac_x_io   = x_q;
  assign dac_y_io   = y_q;
  assign dac_red_io = rgb_q[2];
  assign dac_grn_io = rgb_q[1];
  assign dac_blu_io = rgb_q[0];
  assign busy       = (state_q != IDLE) || !empty;

endmodule
